axi4_burst_mem: RTL

AXI4_BURST_MEM -- requirements
Module: axi4_burst_mem

---
 rtl/axi4_mem_pkg.sv | 25 ++
 rtl/axi4_burst_addr_gen.sv | 44 ++++
 rtl/axi4_burst_mem.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/axi4_mem_pkg.sv
// Shared burst, response and FSM state definitions for the axi4_burst_mem slave.
package axi4_mem_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-beat word-index sequencing and burst legality check.
// WRAP bursts are only supported when AXI4_MEM_WRAP_EN is defined.
module axi4_burst_addr_gen
  import axi4_mem_pkg::*;
#(
  parameter int IDX_W = 14
) (
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       len,
  input  logic [1:0]       burst,
  output logic [IDX_W-1:0] next_idx,
  output logic             legal
);

  logic [IDX_W-1:0] incr_idx;
  assign incr_idx = idx + IDX_W'(1);

`ifdef AXI4_MEM_WRAP_EN
  // LEN is 2^n-1 for legal wraps, so it doubles as the in-window offset mask.
  logic [IDX_W-1:0] wrap_mask;
  assign wrap_mask = IDX_W'(len);
`else
  logic unused_len;
  assign unused_len = ^len;
`endif

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    next_idx = idx;
    legal    = 1'b1;
    case (burst_t'(burst))
      FIXED: next_idx = idx;
      INCR:  next_idx = incr_idx;
`ifdef AXI4_MEM_WRAP_EN
      WRAP: begin
        legal    = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        next_idx = (idx & ~wrap_mask) | (incr_idx & wrap_mask);
      end
`endif
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/axi4_burst_mem.sv
// AXI4 burst memory slave with independent write and read FSMs over a word array.
// Define AXI4_MEM_WRAP_EN to enable WRAP bursts; otherwise they answer SLVERR.
module axi4_burst_mem
  import axi4_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16,
  parameter int MEMORY_DEPTH = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]              AWLEN,
  input  logic [1:0]              AWBURST,
  input  logic                    AWVALID,
  output logic                    AWREADY,
  input  logic [DATA_WIDTH-1:0]   WDATA,
  input  logic [DATA_WIDTH/8-1:0] WSTRB,
  input  logic                    WLAST,
  input  logic                    WVALID,
  output logic                    WREADY,
  output logic [1:0]              BRESP,
  output logic                    BVALID,
  input  logic                    BREADY,
  input  logic [ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]              ARLEN,
  input  logic [1:0]              ARBURST,
  input  logic                    ARVALID,
  output logic                    ARREADY,
  output logic [DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]              RRESP,
  output logic                    RLAST,
  output logic                    RVALID,
  input  logic                    RREADY
);

  localparam int STRB_W   = DATA_WIDTH / 8;
  localparam int LSB      = $clog2(STRB_W);
  localparam int IDX_W    = ADDR_WIDTH - LSB;
  localparam int DEPTH_AW = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int MEM_AW   = (DEPTH_AW < IDX_W) ? DEPTH_AW : IDX_W;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(MEMORY_DEPTH);
  endfunction

  // Sub-word address bits are ignored: every transfer is full width.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AWADDR, ARADDR};

  // ---------------- write path ----------------
  w_state_t         w_state, w_state_nxt;
  logic [IDX_W-1:0] w_idx, w_idx_nxt;
  logic [7:0]       w_len, w_cnt;
  logic [1:0]       w_burst, w_resp;
  logic             w_err, w_legal, w_beat_last, w_beat_err;
  logic             aw_hs, w_hs, mem_we;

  axi4_burst_addr_gen #(.IDX_W(IDX_W)) u_w_addr (
    .idx     (w_idx),
    .len     (w_len),
    .burst   (w_burst),
    .next_idx(w_idx_nxt),
    .legal   (w_legal)
  );

  assign aw_hs       = AWVALID && AWREADY;
  assign w_hs        = WVALID && WREADY;
  assign w_beat_last = (w_cnt == w_len);
  assign w_beat_err  = !w_legal || !in_range(w_idx) || (WLAST != w_beat_last);
  assign mem_we      = w_hs && w_legal && in_range(w_idx);
  assign BRESP       = BVALID ? w_resp : OKAY;

  always_comb begin
    w_state_nxt = w_state;
    AWREADY     = 1'b0;
    WREADY      = 1'b0;
    BVALID      = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = 1'b1;
        if (AWVALID) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID && w_beat_last) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  // The error flag is sticky across the burst; the response is latched on the final beat.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_idx   <= '0;
      w_len   <= '0;
      w_burst <= FIXED;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      w_resp  <= OKAY;
    end else if (aw_hs) begin
      w_idx   <= AWADDR[ADDR_WIDTH-1:LSB];
      w_len   <= AWLEN;
      w_burst <= AWBURST;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_idx <= w_idx_nxt;
      w_cnt <= w_cnt + 8'd1;
      w_err <= w_err | w_beat_err;
      if (w_beat_last) w_resp <= (w_err || w_beat_err) ? SLVERR : OKAY;
    end
  end

  // NOTE: the array has no reset; contents survive ARESETn, and writes are gated by the FSM.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (WSTRB[b]) mem[w_idx[MEM_AW-1:0]][b*8 +: 8] <= WDATA[b*8 +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_t         r_state, r_state_nxt;
  logic [IDX_W-1:0] r_idx, rg_idx, rg_idx_nxt;
  logic [7:0]       r_len, r_cnt, rg_len, cnt_cur;
  logic [1:0]       r_burst, rg_burst;
  logic             rg_legal, ar_hs, r_hs, fetch, fetch_ok;

  // In idle the generator sees the AR channel so the first beat is fetched at the handshake.
  assign rg_idx   = (r_state == R_IDLE) ? ARADDR[ADDR_WIDTH-1:LSB] : r_idx;
  assign rg_len   = (r_state == R_IDLE) ? ARLEN : r_len;
  assign rg_burst = (r_state == R_IDLE) ? ARBURST : r_burst;
  assign cnt_cur  = (r_state == R_IDLE) ? 8'd0 : r_cnt;

  axi4_burst_addr_gen #(.IDX_W(IDX_W)) u_r_addr (
    .idx     (rg_idx),
    .len     (rg_len),
    .burst   (rg_burst),
    .next_idx(rg_idx_nxt),
    .legal   (rg_legal)
  );

  assign ar_hs    = ARVALID && ARREADY;
  assign r_hs     = RVALID && RREADY;
  assign fetch    = ar_hs || (r_hs && !RLAST);
  assign fetch_ok = rg_legal && in_range(rg_idx);

  always_comb begin
    r_state_nxt = r_state;
    ARREADY     = 1'b0;
    RVALID      = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = 1'b1;
        if (ARVALID) r_state_nxt = R_DATA;
      end
      R_DATA: begin
        RVALID = 1'b1;
        if (RREADY && RLAST) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  // Read beats are registered, so a stalled beat holds and a same-cycle write is not seen.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_idx   <= '0;
      r_len   <= '0;
      r_burst <= FIXED;
      r_cnt   <= '0;
      RDATA   <= '0;
      RRESP   <= OKAY;
      RLAST   <= 1'b0;
    end else if (fetch) begin
      r_idx   <= rg_idx_nxt;
      r_len   <= rg_len;
      r_burst <= rg_burst;
      r_cnt   <= cnt_cur + 8'd1;
      RDATA   <= fetch_ok ? mem[rg_idx[MEM_AW-1:0]] : '0;
      RRESP   <= fetch_ok ? OKAY : SLVERR;
      RLAST   <= (cnt_cur == rg_len);
    end
  end

endmodule
